data_memory_bus_initiator: RTL

Initiator (master) end of the core's data memory bus. It converts single load/store requests from the execute stage into word-lane bus transactions with byte enables, and honours the responder's `wait_req`/`valid` handshake. It returns aligned, sign- or zero-extended load data to the core. It sits between the core datapath and the data memory bus responder; only one transaction is outstanding at a time.

---
 rtl/data_memory_bus_initiator.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_bus_initiator.sv
// data_memory_bus_initiator
//
// Initiator end of the core's data memory bus. It takes one load or store at a time from the
// execute stage and turns it into a word-lane bus request with byte enables. It holds that
// request through responder stalls, then returns aligned, sign- or zero-extended load data.
//
// Parameters
//   TIMEOUT_CYCLES   cycles allowed in REQ+RESP before the access is aborted with an error
//                    (0 disables the timeout)
//
// Build option
//   DATA_BUS_MISALIGN_CHECK_EN  when defined, misaligned half/word accesses complete at once
//                               with core_error and generate no bus activity
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   core_read/core_write  start a load/store (sampled when core_busy = 0)
//   core_address          byte address
//   core_write_data       right-justified store data
//   core_size             00 byte, 01 half, 10 word, 11 illegal
//   core_unsigned         zero-extend (1) or sign-extend (0) load data
//   core_read_data        extended load result, held until the next load completes
//   core_busy             transaction in flight (REQ or RESP)
//   core_done             one-cycle completion pulse
//   core_error            qualifies core_done: the access failed
//   bus_address           word-aligned request address
//   bus_write_data        lane-replicated store data
//   bus_byte_enable       active byte lanes
//   bus_read_enable       read request
//   bus_write_enable      write request
//   bus_wait_req          responder stall; request held while high
//   bus_read_data         read data word
//   bus_valid             read data valid

module data_memory_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  output logic [31:0] core_read_data,
  output logic        core_busy,
  output logic        core_done,
  output logic        core_error,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic        bus_wait_req,
  input  logic [31:0] bus_read_data,
  input  logic        bus_valid
);

  // Counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CountW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CountW-1:0] CountLast = CountW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               re_q, re_d;
  logic               we_q, we_d;
  logic [1:0]         offset_q, offset_d;
  logic [1:0]         size_q, size_d;
  logic               unsigned_q, unsigned_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               error_q, error_d;
  logic [CountW-1:0]  count_q, count_d;

  // Request decode from the core side (only used in IDLE/DONE).
  logic        req_any;
  logic        misalign;
  logic        illegal;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [1:0]  lane_offset;

  // Load alignment and extension.
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  assign req_any = core_read | core_write;

`ifdef DATA_BUS_MISALIGN_CHECK_EN
  assign misalign = ((core_size == 2'b01) & core_address[0]) |
                    ((core_size == 2'b10) & (core_address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign illegal = (core_read & core_write) | (core_size == 2'b11) | misalign;

  always_comb begin
    lane_be     = 4'b1111;
    lane_wdata  = core_write_data;
    lane_offset = 2'b00;
    case (core_size)
      2'b00: begin
        lane_be     = 4'b0001 << core_address[1:0];
        lane_wdata  = {4{core_write_data[7:0]}};
        lane_offset = core_address[1:0];
      end
      2'b01: begin
        // Halves select their lane pair from a[1] only; a[0] is ignored.
        lane_be     = core_address[1] ? 4'b1100 : 4'b0011;
        lane_wdata  = {2{core_write_data[15:0]}};
        lane_offset = {core_address[1], 1'b0};
      end
      default: begin
        lane_be     = 4'b1111;
        lane_wdata  = core_write_data;
        lane_offset = 2'b00;
      end
    endcase
  end

  always_comb begin
    shifted  = bus_read_data >> {offset_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00: load_ext = unsigned_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = unsigned_q ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == CountLast);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    re_d       = re_q;
    we_d       = we_q;
    offset_d   = offset_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (req_any) begin
          if (illegal) begin
            state_d = StDone;
            error_d = 1'b1;
          end else begin
            state_d    = StReq;
            error_d    = 1'b0;
            addr_d     = {core_address[31:2], 2'b00};
            wdata_d    = lane_wdata;
            be_d       = lane_be;
            re_d       = core_read;
            we_d       = core_write;
            offset_d   = lane_offset;
            size_d     = core_size;
            unsigned_d = core_unsigned;
            count_d    = '0;
          end
        end
      end

      StReq: begin
        if (!bus_wait_req && we_q) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else if (timeout_hit) begin
          // Abort wins over a read accepted in the final cycle: no budget is left for RESP.
          re_d    = 1'b0;
          we_d    = 1'b0;
          error_d = 1'b1;
          state_d = StDone;
        end else if (!bus_wait_req) begin
          re_d    = 1'b0;
          we_d    = 1'b0;
          count_d = count_q + CountW'(1);
          state_d = StResp;
        end else begin
          count_d = count_q + CountW'(1);
        end
      end

      StResp: begin
        if (bus_valid) begin
          rdata_d = load_ext;
          state_d = StDone;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          count_d = count_q + CountW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      offset_q   <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      re_q       <= re_d;
      we_q       <= we_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign core_read_data   = rdata_q;
  assign core_busy        = (state_q == StReq) || (state_q == StResp);
  assign core_done        = (state_q == StDone);
  assign core_error       = (state_q == StDone) && error_q;
  assign bus_address      = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_byte_enable  = be_q;
  assign bus_read_enable  = re_q;
  assign bus_write_enable = we_q;

endmodule
